wptr_full_ctrl: RTL and testbench

//  Write-domain pointer and flag controller for the async CDC FIFO.
//  - Owns the binary write pointer and the registered Gray write pointer. The Gray pointer feeds
//    the 2-flop pointer synchronizer into the read domain.
//  - Takes the read pointer back as a Gray value, already double-synchronized into this domain.
//  - Gates writes, and produces full, almost_full, fill level and a sticky overflow flag.

---
 rtl/wptr_full_ctrl.sv | 103 ++++++++++
 tb/tb_wptr_full_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain side of the async FIFO. It keeps the binary and Gray write
// pointers, gates producer writes against the synchronized read pointer, and flags
// full / almost_full / fill level plus a sticky overflow indication.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  input  logic                  ovf_clr,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_LIMIT = PW'(AF_THRESH);

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray: adjacent values differ in exactly one bit.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wgray;
  logic          r_full;
  logic          r_almost_full;
  logic [PW-1:0] r_level;
  logic          r_overflow;

  logic          w_accept;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_full_match;
  logic [PW-1:0] w_level_next;

  // Next-state arithmetic for pointers and flags; the read pointer only reaches outputs via flops.
  always_comb begin
    w_accept     = wr_en & ~r_full;
    w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_accept};
    w_wgray_next = bin2gray(w_wbin_next);
    w_rbin       = gray2bin(rptr_gray_sync);
    // Full means the write pointer is exactly one lap ahead: top two Gray bits inverted.
    w_full_match = {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_sync[ADDR_WIDTH-2:0]};
    w_level_next = w_wbin_next - w_rbin;
  end

  // Pointer, flag and level registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wbin        <= {PW{1'b0}};
      r_wgray       <= {PW{1'b0}};
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= {PW{1'b0}};
    end else begin
      r_wbin        <= w_wbin_next;
      r_wgray       <= w_wgray_next;
      r_full        <= (w_wgray_next == w_full_match);
      r_almost_full <= (w_level_next >= AF_LIMIT);
      r_level       <= w_level_next;
    end
  end

  // Sticky overflow: a write attempted while full sets it and takes priority over a clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (wr_en && r_full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign wr_accept   = w_accept;
  assign waddr       = r_wbin[ADDR_WIDTH-1:0];
  assign wptr_gray   = r_wgray;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wr_level    = r_level;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed table, hand-written corner sequences and randomized traffic
// checked against a counting model of the write-side FIFO controller.
module tb_wptr_full_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [4:0] rptr_gray_sync;
  logic       ovf_clr;
  logic       wr_accept;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: unwrapped counts of entries written and read, plus flags.
  int   m_w;
  int   m_r;
  logic m_full;
  logic m_ovf;

  wptr_full_ctrl #(.ADDR_WIDTH(4), .AF_THRESH(12)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rptr_gray_sync(rptr_gray_sync),
    .ovf_clr(ovf_clr), .wr_accept(wr_accept), .waddr(waddr), .wptr_gray(wptr_gray),
    .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [4:0] rptr;
    logic       clr;
    logic       exp_acc;
    logic [4:0] exp_gray;
    logic [3:0] exp_waddr;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_af;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[24];

  function automatic logic [4:0] g5(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [4:0] eg, input logic [3:0] ea,
                             input logic [4:0] el, input logic ef, input logic eaf, input logic eo);
    chk({tag, "_gray"},  {27'd0, wptr_gray},   {27'd0, eg});
    chk({tag, "_waddr"}, {28'd0, waddr},       {28'd0, ea});
    chk({tag, "_level"}, {27'd0, wr_level},    {27'd0, el});
    chk({tag, "_full"},  {31'd0, full},        {31'd0, ef});
    chk({tag, "_af"},    {31'd0, almost_full}, {31'd0, eaf});
    chk({tag, "_ovf"},   {31'd0, overflow},    {31'd0, eo});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    wr_en = 1'b1;
    ovf_clr = 1'b0;
    rptr_gray_sync = 5'd0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
    end
    m_w = 0; m_r = 0; m_full = 1'b0; m_ovf = 1'b0;
    rst = 1'b1;
    wr_en = 1'b0;
  endtask

  // One model-checked cycle; rn is the unwrapped read count presented this cycle.
  task automatic mcyc(input logic we, input int rn, input logic clr, input string tag);
    logic       acc;
    logic [4:0] prev_gray;
    int         lvl;
    wr_en = we;
    ovf_clr = clr;
    rptr_gray_sync = g5(rn);
    acc = we && !m_full;
    #1;
    chk({tag, "_acc"}, {31'd0, wr_accept}, {31'd0, acc});
    prev_gray = wptr_gray;
    @(posedge clk); #1;
    if (we && m_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (acc) m_w++;
    m_r = rn;
    lvl = m_w - m_r;
    m_full = (lvl == 16);
    chk({tag, "_flip"}, $countones(prev_gray ^ wptr_gray), acc ? 32'd1 : 32'd0);
    chk_outputs(tag, g5(m_w), 4'(m_w % 16), 5'(lvl), m_full, lvl >= 12, m_ovf);
  endtask

  initial begin
    int w_d1, w_d2, rn, rate;

    // Directed table: fill to full, write while full, clear, drain one, refill.
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, 5'd0, 1'b0, 1'b1, g5(i + 1), 4'((i + 1) % 16), 5'(i + 1),
                 (i == 15), (i + 1 >= 12), 1'b0};
    end
    for (int i = 16; i < 19; i++) begin
      tbl[i] = '{1'b1, 5'd0, 1'b0, 1'b0, 5'b11000, 4'd0, 5'd16, 1'b1, 1'b1, 1'b1};
    end
    tbl[19] = '{1'b0, 5'd0,     1'b1, 1'b0, 5'b11000, 4'd0, 5'd16, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 5'b00001, 1'b0, 1'b0, 5'b11000, 4'd0, 5'd15, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b1, 5'b00001, 1'b0, 1'b1, 5'b11001, 4'd1, 5'd16, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{1'b1, 5'b00001, 1'b0, 1'b0, 5'b11001, 4'd1, 5'd16, 1'b1, 1'b1, 1'b1};
    tbl[23] = '{1'b1, 5'b00001, 1'b1, 1'b0, 5'b11001, 4'd1, 5'd16, 1'b1, 1'b1, 1'b1};

    // Reset for two cycles, then idle: everything stays zero.
    do_reset(2);
    chk_outputs("rst", 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_outputs("idle", 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      wr_en = tbl[i].wr_en;
      rptr_gray_sync = tbl[i].rptr;
      ovf_clr = tbl[i].clr;
      #1;
      chk($sformatf("tbl%0d_acc", i), {31'd0, wr_accept}, {31'd0, tbl[i].exp_acc});
      @(posedge clk); #1;
      chk_outputs($sformatf("tbl%0d", i), tbl[i].exp_gray, tbl[i].exp_waddr,
                  tbl[i].exp_level, tbl[i].exp_full, tbl[i].exp_af, tbl[i].exp_ovf);
    end

    // 40 writes with the read pointer trailing by two cycles: wraps, never full.
    do_reset(1);
    w_d1 = 0; w_d2 = 0;
    for (int k = 0; k < 40; k++) begin
      mcyc(1'b1, w_d2, 1'b0, "wrap");
      w_d2 = w_d1;
      w_d1 = m_w;
    end
    chk("wrap_count", m_w, 40);

    // Reset mid-operation with nine entries stored.
    do_reset(1);
    for (int k = 0; k < 9; k++) mcyc(1'b1, 0, 1'b0, "pre");
    chk("pre_level", {27'd0, wr_level}, 32'd9);
    do_reset(1);
    chk_outputs("midrst", 5'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    mcyc(1'b1, 0, 1'b0, "post");
    chk("post_waddr", {28'd0, waddr}, 32'd1);

    // Randomized traffic: a slow reader phase (fills up, overflows) then a faster one.
    do_reset(1);
    for (int k = 0; k < 600; k++) begin
      rate = (k < 300) ? 3 : 1;
      rn = m_r;
      if (rn < m_w && $urandom_range(0, rate) == 0) rn++;
      mcyc($urandom_range(0, 3) != 0, rn, $urandom_range(0, 7) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
